// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type, default sizes and index-width helper for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 15;
  // Wide enough for the largest legal TIMEOUT of 255.
  localparam int CNT_W       = 8;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - combinational round-robin winner search starting at ptr
module mem_rr_pick
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // ptr is always below NUM_REQ, so one subtraction is enough to wrap.
  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req_valid[wrap(ptr, k)]) begin
        any                  = 1'b1;
        onehot[wrap(ptr, k)] = 1'b1;
        idx                  = wrap(ptr, k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing the controller's system command port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      cmd_valid_sys,
  output logic                      we_sys,
  output logic [ADDR_W-1:0]         addr_sys,
  inout  wire  [DATA_W-1:0]         data_sys,
  input  logic                      ready_sys
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_e          state, state_n;
  logic [IW-1:0]       ptr, ptr_n, pick_idx;
  logic [NUM_REQ-1:0]  pick_oh, owner_oh;
  logic                pick_any;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [CNT_W-1:0]    cnt;
  logic                cnt_hit;

  mem_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .onehot    (pick_oh),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  assign cnt_hit = (cnt == CNT_W'(TIMEOUT));
  assign ptr_n   = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_any) state_n = ISSUE;
      ISSUE:   if (ready_sys || cnt_hit) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant is gated by reset so nothing is offered while the arbiter is held.
  assign req_grant     = (state == IDLE && reset) ? pick_oh : '0;
  assign cmd_valid_sys = (state == ISSUE);
  assign we_sys        = cmd_valid_sys & lat_we;
  assign addr_sys      = cmd_valid_sys ? lat_addr : '0;
  assign data_sys      = we_sys ? lat_wdata : 'z;
  assign rsp_valid     = (state == RESP) ? owner_oh : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      owner_oh  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          ptr       <= ptr_n;
          owner_oh  <= pick_oh;
          lat_we    <= req_we[pick_idx];
          lat_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
          lat_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
          cnt       <= '0;
        end
        // Ready is checked before the limit so a same-cycle ready is not an error.
        ISSUE: begin
          if (ready_sys) begin
            rsp_rdata <= lat_we ? '0 : data_sys;
            rsp_err   <= 1'b0;
          end else if (cnt_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
